// File: rtl/arp_rx_parser.sv
// Byte-serial ARP receive parser: validates Ethernet+ARP headers, emits CAM learn and reply-request pulses.
// Build macro ARP_TPA_FILTER_EN: when defined, learning is restricted to ARP frames whose TPA equals local_ip.
module arp_rx_parser #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 48,
    parameter bit CHECK_DST_MAC = 1'b1,
    parameter int CNT_WIDTH     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] local_mac,
    input  logic [ADDR_WIDTH-1:0] local_ip,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_last,
    input  logic                  rx_error,
    output logic                  cam_write_en,
    output logic [ADDR_WIDTH-1:0] cam_write_key,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  reply_req,
    output logic [DATA_WIDTH-1:0] reply_mac,
    output logic [ADDR_WIDTH-1:0] reply_ip
);

    localparam int OFF_LAST_HDR = 41;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARSE,
        S_DROP,
        S_COMMIT
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_n;
    logic                  r_da_bcast;
    logic                  r_da_local;
    logic [15:0]           r_oper;
    logic [DATA_WIDTH-1:0] r_sha;
    logic [ADDR_WIDTH-1:0] r_spa;
    logic [ADDR_WIDTH-1:0] r_tpa;
    logic [ADDR_WIDTH-1:0] w_tpa_n;

    logic                  r_cam_we;
    logic [ADDR_WIDTH-1:0] r_cam_key;
    logic [DATA_WIDTH-1:0] r_cam_data;
    logic                  r_reply;
    logic [DATA_WIDTH-1:0] r_reply_mac;
    logic [ADDR_WIDTH-1:0] r_reply_ip;

    logic                  w_start;
    logic                  w_hdr;
    int                    w_off;
    logic [7:0]            w_lm_byte;
    logic                  w_bc_n;
    logic                  w_lm_n;
    logic                  w_byte_ok;
    logic                  w_commit;
    logic                  w_learn;
    logic                  w_reply;

    // A byte arriving in IDLE or COMMIT is offset 0 of a new frame.
    assign w_start = rx_valid && (r_state == S_IDLE || r_state == S_COMMIT);
    assign w_hdr   = w_start || (rx_valid && r_state == S_PARSE);
    assign w_off   = w_start ? 0 : int'(r_cnt);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_lm_byte = 8'h00;
        case (w_off)
            0:       w_lm_byte = local_mac[47:40];
            1:       w_lm_byte = local_mac[39:32];
            2:       w_lm_byte = local_mac[31:24];
            3:       w_lm_byte = local_mac[23:16];
            4:       w_lm_byte = local_mac[15:8];
            5:       w_lm_byte = local_mac[7:0];
            default: w_lm_byte = 8'h00;
        endcase

        w_bc_n = (w_start ? 1'b1 : r_da_bcast) && (rx_data == 8'hFF);
        w_lm_n = (w_start ? 1'b1 : r_da_local) && (rx_data == w_lm_byte);

        w_byte_ok = 1'b1;
        case (w_off)
            0, 1, 2, 3, 4, 5: w_byte_ok = !CHECK_DST_MAC || w_bc_n || w_lm_n;
            12:      w_byte_ok = (rx_data == 8'h08);
            13:      w_byte_ok = (rx_data == 8'h06);
            14:      w_byte_ok = (rx_data == 8'h00);
            15:      w_byte_ok = (rx_data == 8'h01);
            16:      w_byte_ok = (rx_data == 8'h08);
            17:      w_byte_ok = (rx_data == 8'h00);
            18:      w_byte_ok = (rx_data == 8'h06);
            19:      w_byte_ok = (rx_data == 8'h04);
            20:      w_byte_ok = (rx_data == 8'h00);
            21:      w_byte_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
            default: w_byte_ok = 1'b1;
        endcase
    end

    // TPA may complete on the rx_last byte itself, so commit decisions use its next value.
    assign w_tpa_n = (w_hdr && w_off >= 38 && w_off <= 41) ? {r_tpa[ADDR_WIDTH-9:0], rx_data} : r_tpa;

`ifdef ARP_TPA_FILTER_EN
    assign w_learn = (r_spa != '0) && !r_sha[40] && (w_tpa_n == local_ip);
`else
    assign w_learn = (r_spa != '0) && !r_sha[40];
`endif
    assign w_reply = (r_oper == 16'h0001) && (w_tpa_n == local_ip);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
                if (rx_valid && !rx_last) begin
                    w_cnt_n   = CNT_WIDTH'(1);
                    w_state_n = w_byte_ok ? S_PARSE : S_DROP;
                end
            end
            S_PARSE: begin
                if (rx_valid) begin
                    // Saturate so long padding never wraps back into header offsets.
                    w_cnt_n = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    if (rx_last) begin
                        if (w_byte_ok && w_off >= OFF_LAST_HDR && !rx_error) begin
                            w_state_n = S_COMMIT;
                            w_commit  = 1'b1;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end else if (!w_byte_ok) begin
                        w_state_n = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (rx_valid && rx_last) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_da_bcast  <= 1'b0;
            r_da_local  <= 1'b0;
            r_oper      <= '0;
            r_sha       <= '0;
            r_spa       <= '0;
            r_tpa       <= '0;
            r_cam_we    <= 1'b0;
            r_cam_key   <= '0;
            r_cam_data  <= '0;
            r_reply     <= 1'b0;
            r_reply_mac <= '0;
            r_reply_ip  <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_tpa   <= w_tpa_n;

            if (w_hdr && w_off <= 5) begin
                r_da_bcast <= w_bc_n;
                r_da_local <= w_lm_n;
            end
            if (w_hdr && w_off >= 20 && w_off <= 21) begin
                r_oper <= {r_oper[7:0], rx_data};
            end
            if (w_hdr && w_off >= 22 && w_off <= 27) begin
                r_sha <= {r_sha[DATA_WIDTH-9:0], rx_data};
            end
            if (w_hdr && w_off >= 28 && w_off <= 31) begin
                r_spa <= {r_spa[ADDR_WIDTH-9:0], rx_data};
            end

            // Payload registers only move on an actual pulse, so they hold the last committed value.
            r_cam_we <= w_commit && w_learn;
            r_reply  <= w_commit && w_reply;
            if (w_commit && w_learn) begin
                r_cam_key  <= r_spa;
                r_cam_data <= r_sha;
            end
            if (w_commit && w_reply) begin
                r_reply_ip  <= r_spa;
                r_reply_mac <= r_sha;
            end
        end
    end

    assign cam_write_en   = r_cam_we;
    assign cam_write_key  = r_cam_key;
    assign cam_write_data = r_cam_data;
    assign reply_req      = r_reply;
    assign reply_mac      = r_reply_mac;
    assign reply_ip       = r_reply_ip;

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
Byte-serial receive-side ARP parser in the Ethernet MMIO peripheral, between the RX MAC byte stream and the ARP cache CAM. It validates Ethernet+ARP headers and emits a one-cycle CAM write of sender IP (key) to sender MAC (data). It also flags ARP requests addressed to the local IP so the TX side can generate a reply.

Parameters:
ADDR_WIDTH, 32, CAM key width (protocol IPv4 address); must be 32
DATA_WIDTH, 48, CAM data width (MAC address); must be 48
CHECK_DST_MAC, 1, 1 = accept only broadcast or local_mac destination; 0 = accept any destination
CNT_WIDTH, 11, byte counter width; saturates at all-ones

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
local_mac  input  48  station MAC, byte 0 = bits [47:40]
local_ip  input  32  station IPv4, byte 0 = bits [31:24]
rx_data  input  8  frame byte, destination MAC first
rx_valid  input  1  rx_data valid this cycle; no backpressure
rx_last  input  1  qualifies final byte of frame (with rx_valid)
rx_error  input  1  FCS/PHY error, sampled with rx_last
cam_write_en  output  1  one-cycle learn pulse to CAM
cam_write_key  output  32  sender protocol address (SPA)
cam_write_data  output  48  sender hardware address (SHA)
reply_req  output  1  one-cycle pulse: ARP request for local_ip received
reply_mac  output  48  requester SHA, valid with reply_req
reply_ip  output  32  requester SPA, valid with reply_req

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset: state IDLE, byte counter 0, all outputs 0, captured fields 0.
- Byte offsets: 0-5 DA, 6-11 SA, 12-13 ethertype, 14-15 HTYPE, 16-17 PTYPE, 18 HLEN, 19 PLEN, 20-21 OPER, 22-27 SHA, 28-31 SPA, 32-37 THA, 38-41 TPA, 42+ padding (ignored).
- States:
  - IDLE: first rx_valid byte is offset 0 and goes to PARSE.
  - PARSE: check each byte on arrival.
  - DROP: discard bytes until rx_last.
  - COMMIT: one cycle of output pulses, then IDLE.
- PARSE checks (first mismatch goes to DROP):
  - DA: broadcast FF:FF:FF:FF:FF:FF or local_mac, only when CHECK_DST_MAC=1.
  - Fixed fields: ethertype 0x0806, HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04.
  - OPER: 0x0001 or 0x0002.
- Field capture: SHA, SPA, TPA and OPER are shifted in MSB-first.
- rx_last in PARSE:
  - If offset >= 41 and rx_error=0, go to COMMIT.
  - Otherwise (runt or error), go to IDLE with no output.
- rx_last in DROP: go to IDLE.
- rx_last on a byte received in IDLE: a 1-byte frame; stay in IDLE.
- Gaps: rx_valid=0 cycles hold state and counter.
- Counter: saturates at 2^CNT_WIDTH-1; no wrap, so padding never re-enters header offsets.
- COMMIT, in the cycle after the rx_last byte (latency 1 clk):
  - cam_write_en=1 with key=SPA, data=SHA. Suppressed if SPA==0 (ARP probe) or SHA has multicast bit [40] set.
  - reply_req=1 with reply_mac=SHA, reply_ip=SPA if OPER==1 and TPA==local_ip. SPA==0 is still allowed here (probe answer).
- Output hold: pulse outputs are 0 in all other cycles. Key/data/reply fields hold their last committed value.
- Back-to-back frames: a byte with rx_valid during COMMIT is accepted as offset 0 of the next frame. COMMIT moves to PARSE instead of IDLE, so there is no byte loss.
- local_mac/local_ip: sampled live. Changes mid-frame affect only bytes compared after the change.
- Reset mid-frame: returns to IDLE immediately and no pulse is issued. The next valid byte is treated as offset 0; upstream guarantees frame alignment after reset.

Optional Feature:
Macro ARP_TPA_FILTER_EN.
- Defined: cam_write_en is additionally gated by TPA==local_ip; the station learns only ARP addressed to itself.
- Undefined: learns from every valid ARP frame (gratuitous ARP and third-party requests included).
- reply_req behaviour is identical in both builds.

Test Plan:
1. Broadcast request (DA FF.., OPER 1, SHA 02:11:22:33:44:55, SPA 0A000002, TPA = local_ip 0A000001), 60 bytes with padding -> cycle after rx_last: cam_write_en=1 key 0A000002 data 021122334455; reply_req=1 with the same values.
2. Ethertype 0x0800 frame, 64 bytes -> no pulses; state returns to IDLE at rx_last; a following valid ARP reply is learned.
3. Valid ARP with rx_error=1 on last byte, and a runt ending at offset 30 -> no pulses in either case.
4. ARP reply, TPA 0A0000FE != local_ip -> cam_write_en=1 without the macro, 0 with ARP_TPA_FILTER_EN; reply_req=0 in both.
5. Probe (OPER 1, SPA 00000000, TPA = local_ip) -> cam_write_en=0, reply_req=1.
6. Two ARP frames back-to-back with no idle cycle, then rst asserted at offset 25 of a third frame -> two commits with correct keys; no pulse for the third; outputs 0 after reset.
